// File: rtl/split_assign_enumerator_if.sv
// Candidate/result bundle between the solver control, the enumerator and one split checker.
// The slave modport is the enumerator's view; master is the controller/checker side.
interface split_assign_enumerator_if #(
  parameter int W = 13
);
  logic         start;
  logic         abort;
  logic [W-1:0] seed;
  logic [W-1:0] limit;
  logic         busy;
  logic [W-1:0] cand_out;
  logic         cand_valid;
  logic         sat_in;
  logic         res_valid;
  logic         res_ready;
  logic         res_found;
  logic [W-1:0] res_assign;
  logic [W:0]   res_tried;

  modport slave (
    input  start, abort, seed, limit, sat_in, res_ready,
    output busy, cand_out, cand_valid, res_valid, res_found, res_assign, res_tried
  );

  modport master (
    output start, abort, seed, limit, sat_in, res_ready,
    input  busy, cand_out, cand_valid, res_valid, res_found, res_assign, res_tried
  );
endinterface

// File: rtl/split_assign_enumerator.sv
// Walks candidate assignments from a seed, holds each for the checker latency and reports
// the first satisfying one or exhaustion of the requested range.
//
// state | meaning
// IDLE  | waiting for start; result fields keep their last values
// EVAL  | driving cand to the checker; sampling sat_in on the last hold cycle
// DONE  | presenting the result until res_ready
module split_assign_enumerator #(
  parameter int W         = 13,
  parameter int CHECK_LAT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  split_assign_enumerator_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  localparam int            HW        = (CHECK_LAT > 0) ? $clog2(CHECK_LAT + 1) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(CHECK_LAT);

  state_t        state, state_nxt;
  logic [W-1:0]  cand;
  logic [W:0]    tried;
  logic [W:0]    lim;
  logic [HW-1:0] hold;
  logic          found;
  logic [W-1:0]  hit_assign;

  logic          sample;
  logic          go_idle;
  logic          tried_last;
  logic [W:0]    tried_inc;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    sample     = 1'b0;
    tried_inc  = tried + 1'b1;
    tried_last = (tried_inc == lim);
    go_idle    = bus.abort && (state != IDLE);
    case (state)
      IDLE: if (bus.start) state_nxt = EVAL;
      EVAL: begin
        sample = (hold == '0);
        if (sample && (bus.sat_in || tried_last)) state_nxt = DONE;
      end
      DONE: if (bus.res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (go_idle) state_nxt = IDLE;
  end

  // Hold is a down-counter; the checker result is only trusted when it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= '0;
      tried      <= '0;
      lim        <= '0;
      hold       <= '0;
      found      <= 1'b0;
      hit_assign <= '0;
    end else if (!go_idle) begin
      case (state)
        IDLE: if (bus.start) begin
          cand  <= bus.seed;
          tried <= '0;
          hold  <= HOLD_LOAD;
          lim   <= (bus.limit == '0) ? {1'b1, {W{1'b0}}} : {1'b0, bus.limit};
        end
        EVAL: begin
          if (sample) begin
            tried <= tried_inc;
            if (bus.sat_in || tried_last) begin
              found      <= bus.sat_in;
              hit_assign <= cand;
            end else begin
              cand <= cand + 1'b1;
              hold <= HOLD_LOAD;
            end
          end else begin
            hold <= hold - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.cand_valid = (state == EVAL);
  assign bus.cand_out   = cand;
  assign bus.res_valid  = (state == DONE);
  assign bus.res_found  = found;
  assign bus.res_assign = hit_assign;
  assign bus.res_tried  = tried;
endmodule

// File: tb/tb_split_assign_enumerator.sv
// Directed bench: two enumerators (combinational and 2-cycle checker) with a scoreboard monitor
// that checks candidate streams, results, result stability and idle/reset probes.
module tb_split_assign_enumerator;
  typedef struct {
    logic        found;
    logic [12:0] asg;
    logic [13:0] tried;
    int          cyc;
  } res_t;

  logic clk;
  logic rst0, rst2;
  logic sel0, glitch2;
  int   cyc;
  int   checks, failures;
  logic done;
  int   probe0, probe2;

  logic [12:0] cq0[$];
  logic [12:0] cq2[$];
  res_t        rq0[$];
  res_t        rq2[$];
  res_t        r0, r2;
  logic [27:0] cap0, cap2;
  logic        rv0_prev, rv2_prev;
  logic [12:0] prod0;

  split_assign_enumerator_if #(.W(13)) b0();
  split_assign_enumerator_if #(.W(13)) b2();

  split_assign_enumerator #(.W(13), .CHECK_LAT(0)) dut0 (.clk(clk), .rst(rst0), .bus(b0));
  split_assign_enumerator #(.W(13), .CHECK_LAT(2)) dut2 (.clk(clk), .rst(rst2), .bus(b2));

  // split_0 model: var_48 = cand[12:5], var_0 = cand[4:0], x = |(var_48 * var_0)
  assign prod0     = 13'(b0.cand_out[12:5]) * 13'(b0.cand_out[4:0]);
  assign b0.sat_in = sel0 ? |prod0 : 1'b0;
  assign b2.sat_in = (b2.cand_out == 13'd5) | glitch2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (b0.cand_valid === 1'b1) begin
      if (cq0.size() == 0) chk("cand0_extra", 32'(b0.cand_valid), 32'd0);
      else chk("cand0_seq", 32'(b0.cand_out), 32'(cq0.pop_front()));
    end
    if (b2.cand_valid === 1'b1) begin
      if (cq2.size() == 0) chk("cand2_extra", 32'(b2.cand_valid), 32'd0);
      else chk("cand2_seq", 32'(b2.cand_out), 32'(cq2.pop_front()));
    end

    if (b0.res_valid === 1'b1 && !rv0_prev) begin
      if (rq0.size() == 0) chk("res0_extra", 32'(b0.res_valid), 32'd0);
      else begin
        r0 = rq0.pop_front();
        chk("res0_found", 32'(b0.res_found), 32'(r0.found));
        chk("res0_assign", 32'(b0.res_assign), 32'(r0.asg));
        chk("res0_tried", 32'(b0.res_tried), 32'(r0.tried));
        chk("res0_cycle", 32'(cyc), 32'(r0.cyc));
      end
      cap0 = {b0.res_found, b0.res_assign, b0.res_tried};
    end else if (b0.res_valid === 1'b1) begin
      chk("res0_stable", 32'({b0.res_found, b0.res_assign, b0.res_tried}), 32'(cap0));
    end
    rv0_prev <= (b0.res_valid === 1'b1);

    if (b2.res_valid === 1'b1 && !rv2_prev) begin
      if (rq2.size() == 0) chk("res2_extra", 32'(b2.res_valid), 32'd0);
      else begin
        r2 = rq2.pop_front();
        chk("res2_found", 32'(b2.res_found), 32'(r2.found));
        chk("res2_assign", 32'(b2.res_assign), 32'(r2.asg));
        chk("res2_tried", 32'(b2.res_tried), 32'(r2.tried));
        chk("res2_cycle", 32'(cyc), 32'(r2.cyc));
      end
      cap2 = {b2.res_found, b2.res_assign, b2.res_tried};
    end else if (b2.res_valid === 1'b1) begin
      chk("res2_stable", 32'({b2.res_found, b2.res_assign, b2.res_tried}), 32'(cap2));
    end
    rv2_prev <= (b2.res_valid === 1'b1);

    if (probe0 != 0) begin
      chk("idle0_busy", 32'(b0.busy), 32'd0);
      chk("idle0_cand_valid", 32'(b0.cand_valid), 32'd0);
      chk("idle0_res_valid", 32'(b0.res_valid), 32'd0);
    end
    if (probe0 == 2) begin
      chk("rst0_cand_out", 32'(b0.cand_out), 32'd0);
      chk("rst0_res_found", 32'(b0.res_found), 32'd0);
      chk("rst0_res_assign", 32'(b0.res_assign), 32'd0);
      chk("rst0_res_tried", 32'(b0.res_tried), 32'd0);
    end
    if (probe2 == 2) begin
      chk("rst2_busy", 32'(b2.busy), 32'd0);
      chk("rst2_cand_valid", 32'(b2.cand_valid), 32'd0);
      chk("rst2_res_valid", 32'(b2.res_valid), 32'd0);
      chk("rst2_cand_out", 32'(b2.cand_out), 32'd0);
      chk("rst2_res_tried", 32'(b2.res_tried), 32'd0);
    end

    if (done) begin
      chk("cand0_pending", 32'(cq0.size()), 32'd0);
      chk("cand2_pending", 32'(cq2.size()), 32'd0);
      chk("res0_pending", 32'(rq0.size()), 32'd0);
      chk("res2_pending", 32'(rq2.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    int t;
    checks = 0; failures = 0; done = 1'b0;
    probe0 = 0; probe2 = 0; rv0_prev = 1'b0; rv2_prev = 1'b0;
    cap0 = '0; cap2 = '0;
    rst0 = 1'b1; rst2 = 1'b1; sel0 = 1'b0; glitch2 = 1'b0;
    b0.start = 1'b0; b0.abort = 1'b0; b0.seed = '0; b0.limit = '0; b0.res_ready = 1'b1;
    b2.start = 1'b0; b2.abort = 1'b0; b2.seed = '0; b2.limit = '0; b2.res_ready = 1'b1;
    repeat (2) tick();
    rst0 = 1'b0; rst2 = 1'b0; probe0 = 2; probe2 = 2;
    tick();
    probe0 = 0; probe2 = 0;

    // Real split_0 checker, full space from 0: first hit at 33
    sel0 = 1'b1; b0.seed = 13'd0; b0.limit = 13'd0; b0.start = 1'b1; t = cyc;
    for (int i = 0; i <= 33; i++) cq0.push_back(13'(i));
    rq0.push_back('{1'b1, 13'd33, 14'd34, t + 35});
    tick();
    b0.start = 1'b0;
    repeat (40) tick();

    // Wrap through zero with limit 4, then hold the result with res_ready low
    sel0 = 1'b0; b0.seed = 13'h1FFE; b0.limit = 13'd4; b0.res_ready = 1'b0; b0.start = 1'b1; t = cyc;
    cq0.push_back(13'h1FFE); cq0.push_back(13'h1FFF); cq0.push_back(13'h0000); cq0.push_back(13'h0001);
    rq0.push_back('{1'b0, 13'h0001, 14'd4, t + 5});
    tick();
    b0.start = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 10; i++) begin
      b0.start = (i == 2);
      b0.seed  = 13'h0055;
      tick();
    end
    b0.res_ready = 1'b1; b0.start = 1'b1;
    tick();
    b0.start = 1'b0; probe0 = 1;
    tick();
    probe0 = 0;

    // Abort a full-space search at T+5, then restart from a new seed
    b0.seed = 13'h0100; b0.limit = 13'd0; b0.start = 1'b1; t = cyc;
    for (int i = 0; i < 5; i++) cq0.push_back(13'h0100 + 13'(i));
    tick();
    b0.start = 1'b0;
    repeat (4) tick();
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0; probe0 = 1;
    repeat (3) tick();
    probe0 = 0;
    b0.seed = 13'h0ABC; b0.limit = 13'd2; b0.start = 1'b1; t = cyc;
    cq0.push_back(13'h0ABC); cq0.push_back(13'h0ABD);
    rq0.push_back('{1'b0, 13'h0ABD, 14'd2, t + 3});
    tick();
    b0.start = 1'b0;
    repeat (4) tick();

    // Reset mid-EVAL
    b0.seed = 13'd0; b0.limit = 13'd0; b0.start = 1'b1;
    cq0.push_back(13'd0); cq0.push_back(13'd1); cq0.push_back(13'd2);
    tick();
    b0.start = 1'b0;
    repeat (2) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0; probe0 = 2;
    tick();
    probe0 = 0;

    // Reset while holding a result in DONE
    b0.seed = 13'd7; b0.limit = 13'd1; b0.res_ready = 1'b0; b0.start = 1'b1; t = cyc;
    cq0.push_back(13'd7);
    rq0.push_back('{1'b0, 13'd7, 14'd1, t + 2});
    tick();
    b0.start = 1'b0;
    repeat (2) tick();
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0; probe0 = 2; b0.res_ready = 1'b1;
    tick();
    probe0 = 0;

    // CHECK_LAT=2: each candidate held 3 cycles, glitch on candidate 4 must be ignored
    b2.seed = 13'd3; b2.limit = 13'd0; b2.start = 1'b1; t = cyc;
    for (int v = 3; v <= 5; v++) repeat (3) cq2.push_back(13'(v));
    rq2.push_back('{1'b1, 13'd5, 14'd3, t + 10});
    tick();
    b2.start = 1'b0;
    repeat (3) tick();
    glitch2 = 1'b1;
    repeat (2) tick();
    glitch2 = 1'b0;
    repeat (8) tick();

    done = 1'b1;
    repeat (3) tick();
    $display("FAIL summary_not_reached checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule

// File: doc/split_assign_enumerator.md
Name: split_assign_enumerator

Overview:
- Sequential stimulus-side counterpart to the combinational split constraint checkers: it generates candidate variable assignments and drives them into a checker.
- The checker returns a single satisfaction bit (x). The block samples it, and reports either the first satisfying assignment or exhaustion of the search range.
- Sits between the solver control logic and one split_N checker instance. The default width covers {var_48[7:0], var_0[4:0]}.

Parameters:
- W, 13, width of the concatenated candidate assignment vector.
- CHECK_LAT, 0, checker pipeline latency in cycles; 0 means purely combinational checker.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle request to begin a search; ignored unless idle
- abort  input  1  synchronous cancel; returns block to IDLE
- seed  input  W  first candidate; sampled with start
- limit  input  W  max candidates to try; 0 = full 2^W space; sampled with start
- busy  output  1  high in any state except IDLE
- cand_out  output  W  candidate assignment driven to the checker
- cand_valid  output  1  cand_out is a live candidate
- sat_in  input  1  checker result x for cand_out
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_found  output  1  1 = satisfying assignment found; 0 = range exhausted
- res_assign  output  W  satisfying candidate; last candidate tried if not found
- res_tried  output  W+1  number of candidates evaluated, including the hit

Behaviour:
- Reset (rst=1 at a clock edge) forces the following, regardless of state:
  - state=IDLE
  - busy=0, cand_valid=0, res_valid=0, res_found=0
  - cand_out=0, res_assign=0, res_tried=0
- FSM states: IDLE, EVAL, DONE.
- IDLE:
  - busy=0.
  - On start=1: cand<=seed, tried<=0, hold counter<=0, limit latched (0 mapped to 2^W); next state EVAL.
  - start while busy has no effect.
- EVAL:
  - busy=1, cand_valid=1, cand_out=cand.
  - Each candidate is held stable for CHECK_LAT+1 cycles.
  - sat_in is sampled only on the last hold cycle; sat_in at other times is ignored.
  - Actions on the sampling cycle:
    - tried<=tried+1 in every case.
    - sat_in=1: res_found<=1, res_assign<=cand, go DONE.
    - sat_in=0 and (tried+1 == latched limit): res_found<=0, res_assign<=cand, go DONE.
    - Otherwise: cand<=cand+1 mod 2^W (wraps from all-ones to 0), hold counter reset, stay EVAL.
  - Full-space search (limit=0) therefore visits every value exactly once, starting at seed and wrapping through 0.
- DONE:
  - cand_valid=0, busy=1, res_valid=1.
  - res_found, res_assign and res_tried are stable while res_valid=1.
  - On res_ready=1: next state IDLE, res_valid<=0. Result fields hold their last values until the next start.
- abort:
  - In any non-IDLE state, abort=1 sends the FSM to IDLE next cycle.
  - cand_valid=0 and res_valid=0 next cycle; the result is discarded.
  - abort has priority over sat_in, limit and res_ready. rst has priority over abort.
- start in the same cycle as the DONE->IDLE handshake is ignored; start is accepted only when the FSM is in IDLE.
- Timing, with start at cycle T and CHECK_LAT=0:
  - cand_out=seed at T+1.
  - One candidate per cycle.
  - A hit at candidate k (0-based) gives res_valid=1 at cycle T+k+2.
- Arithmetic: tried counts up to 2^W, hence W+1 bits. The limit comparison uses W+1 bits.

Test Plan:
- Real split_0 checker (x = |(var_48*var_0) with constants), W=13, CHECK_LAT=0, seed=0, limit=0:
  - Candidates 0..32 fail; 33 = {8'h01, 5'h01} passes.
  - Required: res_found=1, res_assign=13'd33, res_tried=34, res_valid at T+35.
- Stub checker sat_in=0 always, seed=13'h1FFE, limit=4:
  - cand_out sequence 1FFE, 1FFF, 0000, 0001.
  - Required: res_found=0, res_assign=13'h0001, res_tried=4.
- CHECK_LAT=2, stub asserting sat_in only when cand_out=5, seed=3:
  - Each candidate is held 3 cycles.
  - Required: res_assign=5, res_tried=3, res_valid at T+1+9.
  - A sat_in glitch on a non-sampling cycle of candidate 4 must be ignored.
- res_ready held low for 10 cycles in DONE:
  - Required: res_valid and result fields stable; start pulses ignored; IDLE one cycle after res_ready=1.
- abort at cycle T+5 of a full-space search:
  - Required: cand_valid=0, busy=0 and no res_valid from T+6.
  - A new start then begins cleanly from the new seed.
- rst asserted mid-EVAL and again in DONE:
  - Required: all outputs return to reset values on the next edge.
